// File: rtl/ksa_swap.sv
// ksa_swap: RC4 key-scheduling stage, permuting S in place through a single-port RAM.
// Optional build macro KSA_SKIP_SELF_SWAP_EN drops the read/write pair when j == i.
module ksa_swap #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wen,
  output logic                   mem_busy,
  output logic                   finish
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    CAP_I = 3'd2,
    RD_J  = 3'd3,
    CAP_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [8:0]           r_i;
  logic [7:0]           r_j;
  logic [7:0]           r_si;
  logic [7:0]           r_sj;
  logic [KW-1:0]        r_k;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [7:0]           w_key_byte;
  logic [7:0]           w_j_new;
  logic                 w_skip;
  logic                 w_last;
  logic                 w_advance;

  // Key byte k, byte 0 being the most significant byte of the key.
  always_comb begin
    w_key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      w_key_byte = (r_k == KW'(b)) ? r_key[8*(KEY_BYTES-1-b) +: 8] : w_key_byte;
    end
  end

  assign w_j_new = r_j + q + w_key_byte;
  assign w_last  = (r_i == 9'd255);

`ifdef KSA_SKIP_SELF_SWAP_EN
  assign w_skip = (w_j_new == r_i[7:0]);
`else
  assign w_skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-state RAM outputs.
  always_comb begin
    w_next    = r_state;
    address   = 8'h00;
    data      = 8'h00;
    wen       = 1'b0;
    mem_busy  = 1'b0;
    finish    = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RD_I;
        end else begin
          w_next = IDLE;
        end
      end
      RD_I: begin
        mem_busy = 1'b1;
        address  = r_i[7:0];
        w_next   = CAP_I;
      end
      CAP_I: begin
        mem_busy = 1'b1;
        if (w_skip) begin
          w_advance = 1'b1;
          w_next    = w_last ? DONE : RD_I;
        end else begin
          w_next = RD_J;
        end
      end
      RD_J: begin
        mem_busy = 1'b1;
        address  = r_j;
        w_next   = CAP_J;
      end
      CAP_J: begin
        mem_busy = 1'b1;
        w_next   = WR_I;
      end
      WR_I: begin
        mem_busy = 1'b1;
        address  = r_i[7:0];
        data     = r_sj;
        wen      = 1'b1;
        w_next   = WR_J;
      end
      WR_J: begin
        mem_busy  = 1'b1;
        address   = r_j;
        data      = r_si;
        wen       = 1'b1;
        w_advance = 1'b1;
        w_next    = w_last ? DONE : RD_I;
      end
      DONE: begin
        finish = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: key capture, j accumulation, swap operands, i/k stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i   <= 9'd0;
      r_j   <= 8'd0;
      r_k   <= '0;
      r_si  <= 8'd0;
      r_sj  <= 8'd0;
      r_key <= '0;
    end else if (r_state == IDLE && start) begin
      r_key <= secret_key;
      r_i   <= 9'd0;
      r_j   <= 8'd0;
      r_k   <= '0;
    end else begin
      if (r_state == CAP_I) begin
        r_si <= q;
        r_j  <= w_j_new;
      end
      if (r_state == CAP_J) begin
        r_sj <= q;
      end
      if (w_advance && !w_last) begin
        r_i <= r_i + 9'd1;
        r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ksa_swap.sv
// Bench for ksa_swap: RAM models, write-trace scoreboard from a software KSA,
// finish timing, mid-run start/reset behaviour and a KEY_BYTES=5 instance.
module tb_ksa_swap;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start3, start5;
  logic [23:0] key3;
  logic [39:0] key5;
  logic [7:0]  q3, addr3, data3, q5, addr5, data5;
  logic        wen3, busy3, fin3, wen5, busy5, fin5;
  logic        init_req;
  logic [7:0]  mem3 [256];
  logic [7:0]  mem5 [256];
  logic [7:0]  model_s [256];
  logic [15:0] exp_q [$];
  logic [15:0] trace [4];
  logic [7:0]  addr_at_c3;
  int          n_wr;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ksa_swap #(.KEY_BYTES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .secret_key(key3), .q(q3),
    .address(addr3), .data(data3), .wen(wen3), .mem_busy(busy3), .finish(fin3)
  );

  ksa_swap #(.KEY_BYTES(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .secret_key(key5), .q(q5),
    .address(addr5), .data(data5), .wen(wen5), .mem_busy(busy5), .finish(fin5)
  );

  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 256; a++) begin
        mem3[a] <= 8'(a);
        mem5[a] <= 8'(a);
      end
    end else begin
      if (wen3) mem3[addr3] <= data3;
      if (wen5) mem5[addr5] <= data5;
    end
    q3 <= mem3[addr3];
    q5 <= mem5[addr5];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && wen3 === 1'b1) begin
      if (n_wr < 4) trace[n_wr] = {addr3, data3};
      n_wr++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("write_trace", 32'({addr3, data3}), 32'(exp_q.pop_front()));
    end
  end

  task automatic build_model(input logic [39:0] key, input int nb, input bit push);
    logic [7:0] s [256];
    logic [7:0] j, kb, t;
    bit skip;
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(nb-1-(i%nb)) +: 8];
      j  = j + s[i] + kb;
      skip = 1'b0;
`ifdef KSA_SKIP_SELF_SWAP_EN
      skip = (j == 8'(i));
`endif
      if (push && !skip) begin
        exp_q.push_back({8'(i), s[j]});
        exp_q.push_back({j, s[i]});
      end
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    model_s = s;
  endtask

  function automatic int count_bad(input logic [7:0] m [256]);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (m[a] !== model_s[a]) bad++;
    return bad;
  endfunction

  task automatic init_ram();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
  endtask

  task automatic run3(input logic [23:0] key, input int mid_at, input int rst_at, input string tag);
    int fin_cyc = 0;
    int fin_cnt = 0;
    logic busy_c1 = 1'b0;
    init_ram();
    exp_q.delete();
    n_wr = 0;
    build_model({16'h0000, key}, 3, 1'b1);
    @(negedge clk); key3 = key; start3 = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 1700; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start3 = 1'b0; busy_c1 = busy3; end
      if (cyc == 3) addr_at_c3 = addr3;
      if (cyc == mid_at) begin start3 = 1'b1; key3 = ~key; end
      if (cyc == mid_at + 1) start3 = 1'b0;
      if (fin3 === 1'b1) begin
        fin_cnt++;
        if (fin_cyc == 0) fin_cyc = cyc;
      end
      if (cyc == rst_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_wen"},  32'(wen3),  32'd0);
        check({tag, "_rst_busy"}, 32'(busy3), 32'd0);
        check({tag, "_rst_addr"}, 32'(addr3), 32'd0);
        check({tag, "_rst_data"}, 32'(data3), 32'd0);
        exp_q.delete();
        break;
      end
      if (fin_cyc != 0 && cyc == fin_cyc + 1) begin
        check({tag, "_idle_busy"}, 32'(busy3), 32'd0);
        check({tag, "_idle_fin"},  32'(fin3),  32'd0);
        break;
      end
    end
    check({tag, "_busy_c1"}, 32'(busy_c1), 32'd1);
    if (rst_at > 0) begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check({tag, "_post_rst_busy"}, 32'(busy3), 32'd0);
      check({tag, "_post_rst_fin"},  32'(fin_cnt), 32'd0);
    end else begin
      check({tag, "_finished"}, 32'(fin_cyc != 0), 32'd1);
      check({tag, "_fin_cnt"}, 32'(fin_cnt), 32'd1);
`ifndef KSA_SKIP_SELF_SWAP_EN
      check({tag, "_fin_cycle"}, 32'(fin_cyc), 32'd1537);
`endif
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_final_S"}, 32'(count_bad(mem3)), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; start3 = 1'b0; start5 = 1'b0;
    key3 = 24'h0; key5 = 40'h0; init_req = 1'b0;
    n_wr = 0; addr_at_c3 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_addr", 32'(addr3), 32'd0);
    check("reset_data", 32'(data3), 32'd0);
    check("reset_wen",  32'(wen3),  32'd0);
    check("reset_busy", 32'(busy3), 32'd0);
    check("reset_fin",  32'(fin3),  32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run3(24'h010203, -1, -1, "k010203");
`ifndef KSA_SKIP_SELF_SWAP_EN
    check("k010203_w0", 32'(trace[0]), 32'h0001);
    check("k010203_w1", 32'(trace[1]), 32'h0100);
    check("k010203_w2", 32'(trace[2]), 32'h0103);
    check("k010203_w3", 32'(trace[3]), 32'h0300);
`endif

    run3(24'h000000, -1, -1, "k0");
`ifndef KSA_SKIP_SELF_SWAP_EN
    check("k0_w0", 32'(trace[0]), 32'h0000);
    check("k0_w1", 32'(trace[1]), 32'h0000);
`else
    check("k0_skip_addr_c3", 32'(addr_at_c3), 32'd1);
`endif

    run3(24'h5a3cf1, 100, -1, "mid_start");
    run3(24'h123456, -1, 500, "rst");
    run3(24'hc0ffee, -1, -1, "fresh");

    init_ram();
    build_model(40'h0102030405, 5, 1'b0);
    @(negedge clk); key5 = 40'h0102030405; start5 = 1'b1;
    @(posedge clk);
    @(negedge clk); start5 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (fin5 === 1'b1) break;
      @(negedge clk);
    end
    check("kb5_finished", 32'(fin5), 32'd1);
    @(negedge clk);
    check("kb5_final_S", 32'(count_bad(mem5)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
